// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared state encoding, index limits and direction codes
// for the LED scan sequencer.
package led_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } scan_state_e;

    localparam logic [3:0] SEL_MAX = 4'd15;
    localparam logic [3:0] SEL_MIN = 4'd0;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic logic [3:0] sel_step(
        input logic [3:0] s,
        input logic       d
    );
        return (d == DIR_DN) ? s - 4'd1 : s + 4'd1;
    endfunction

endpackage

// File: rtl/led_scan_if.sv
// led_scan_if: control inputs and decoder-side outputs of the scan
// sequencer, grouped for the board-level controller and the sequencer.
interface led_scan_if;

    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    logic       bounce;
    logic [1:0] speed;
    logic [3:0] sel;
    logic       dec_en;
    logic       busy;
    logic       wrap;

    modport master (
        output start, stop, pause, dir, bounce, speed,
        input  sel, dec_en, busy, wrap
    );

    modport slave (
        input  start, stop, pause, dir, bounce, speed,
        output sel, dec_en, busy, wrap
    );

endinterface

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running tick divider with enable, clear and a
// runtime terminal count; ticks whenever the count has reached term.
module scan_prescaler #(
    parameter int DIV_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] term,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= so that lowering term mid-count ticks on the next cycle
    assign tick = en && (cnt >= term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: steps the 4-to-16 LED decoder select at a programmable rate.
// Define LED_SCAN_BOUNCE_EN to enable ping-pong scanning via the bounce input.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int DIV_BASE = 25_000_000,
    parameter int DIV_W    = 30
) (
    input  logic      clk,
    input  logic      rst_n,
    led_scan_if.slave ifc
);

    scan_state_e state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic        dir_q, dir_d;
    logic        wrap_q, wrap_d;
    logic        busy_q;

    logic [DIV_W-1:0] term;
    logic             tick;
    logic             bnc;
    logic             turn;
    logic             mv_dir;
    logic [3:0]       nxt_sel;
    logic             end_hit;

`ifdef LED_SCAN_BOUNCE_EN
    assign bnc = ifc.bounce;
`else
    logic bounce_unused;
    assign bnc = 1'b0;
    assign bounce_unused = ifc.bounce;
`endif

    assign term = (DIV_W'(DIV_BASE) << ifc.speed) - DIV_W'(1);

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (ifc.start),
        .term  (term),
        .tick  (tick)
    );

    // Ping-pong reverses at an endpoint; wrap mode tracks dir live.
    assign turn = (dir_q == DIR_UP && sel_q == SEL_MAX) ||
                  (dir_q == DIR_DN && sel_q == SEL_MIN);
    assign mv_dir  = bnc ? (dir_q ^ turn) : ifc.dir;
    assign nxt_sel = sel_step(sel_q, mv_dir);

    always_comb begin
        end_hit = 1'b0;
        if (bnc) begin
            end_hit = (mv_dir == DIR_UP) ? (nxt_sel == SEL_MAX)
                                         : (nxt_sel == SEL_MIN);
        end else begin
            end_hit = (mv_dir == DIR_UP) ? (nxt_sel == SEL_MIN)
                                         : (nxt_sel == SEL_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (ifc.stop) begin
            state_d = IDLE;
            sel_d   = SEL_MIN;
        end else if (ifc.start) begin
            sel_d   = (ifc.dir == DIR_DN) ? SEL_MAX : SEL_MIN;
            dir_d   = ifc.dir;
            state_d = (state_q != IDLE && ifc.pause) ? HOLD : RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ifc.pause) begin
                        state_d = HOLD;
                    end
                    if (tick) begin
                        sel_d  = nxt_sel;
                        dir_d  = mv_dir;
                        wrap_d = end_hit;
                    end
                end
                HOLD: begin
                    if (!ifc.pause) begin
                        state_d = RUN;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_MIN;
            dir_q   <= DIR_UP;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ifc.sel    = sel_q;
    assign ifc.dec_en = busy_q;
    assign ifc.busy   = busy_q;
    assign ifc.wrap   = wrap_q;

endmodule
